// File: rtl/math_pipelined_stream.sv
// rtl/math_pipelined_stream.sv - chunked, pipelined add/sub/compare ALU with valid/ready handshake.
// Optional signed compares (LTS/GTS) are built only when MATH_PIPELINED_SIGNED_EN is defined.
module math_pipelined_stream #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic [2:0]       out_op
);

  localparam int LAT_EFF         = (LATENCY < 1) ? 1 : LATENCY;
  localparam int ALU_WIDTH       = (WIDTH + LAT_EFF - 1) / LAT_EFF;
  localparam int CHUNK_COUNT     = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
  localparam int LAST_CHUNK_SIZE = WIDTH - (CHUNK_COUNT - 1) * ALU_WIDTH;
  localparam int PW              = CHUNK_COUNT * ALU_WIDTH;
  localparam logic [ALU_WIDTH-1:0] LAST_MASK = {ALU_WIDTH{1'b1}} >> (ALU_WIDTH - LAST_CHUNK_SIZE);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd2;
  localparam logic [2:0] OP_NEQ = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GTU = 3'd5;
`ifdef MATH_PIPELINED_SIGNED_EN
  localparam logic [2:0] OP_LTS = 3'd6;
  localparam logic [2:0] OP_GTS = 3'd7;
`endif

  // Stage k holds operands zero-padded to PW bits; chunk k is processed from stage k.
  logic [CHUNK_COUNT-1:0] vld_q;
  logic [PW-1:0]          a_q  [CHUNK_COUNT];
  logic [PW-1:0]          b_q  [CHUNK_COUNT];
  logic [PW-1:0]          r_q  [CHUNK_COUNT];
  logic [2:0]             op_q [CHUNK_COUNT];
  logic [CHUNK_COUNT-1:0] c_q;
  logic [CHUNK_COUNT-1:0] e_q;

  logic [PW-1:0]          r_d  [CHUNK_COUNT];
  logic [CHUNK_COUNT-1:0] c_d;
  logic [CHUNK_COUNT-1:0] e_d;

  logic                   out_valid_q;
  logic [WIDTH-1:0]       out_result_q;
  logic                   out_carry_q;
  logic [2:0]             out_op_q;

  logic [WIDTH-1:0]       res_d;
  logic                   carry_d;
  logic                   advance;

  logic [ALU_WIDTH-1:0]   ac_c;
  logic [ALU_WIDTH-1:0]   bc_c;
  logic [ALU_WIDTH-1:0]   bx_c;
  logic [ALU_WIDTH:0]     sum_c;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !rst;

  // Every non-ADD op runs A + ~B + 1, so the final carry is the inverse of the borrow.
  always_comb begin
    ac_c  = '0;
    bc_c  = '0;
    bx_c  = '0;
    sum_c = '0;
    c_d   = '0;
    e_d   = '0;
    for (int k = 0; k < CHUNK_COUNT; k++) begin
      ac_c = a_q[k][k*ALU_WIDTH +: ALU_WIDTH];
      bc_c = b_q[k][k*ALU_WIDTH +: ALU_WIDTH];
      bx_c = (op_q[k] != OP_ADD) ? ~bc_c : bc_c;
      if (k == CHUNK_COUNT - 1) begin
        bx_c = bx_c & LAST_MASK;
      end
      sum_c  = {1'b0, ac_c} + {1'b0, bx_c} + {{ALU_WIDTH{1'b0}}, c_q[k]};
      c_d[k] = (k == CHUNK_COUNT - 1) ? sum_c[LAST_CHUNK_SIZE] : sum_c[ALU_WIDTH];
      e_d[k] = e_q[k] && (ac_c == bc_c);
      r_d[k] = r_q[k];
      r_d[k][k*ALU_WIDTH +: ALU_WIDTH] = sum_c[ALU_WIDTH-1:0];
    end
  end

`ifdef MATH_PIPELINED_SIGNED_EN
  logic lts_c;
  assign lts_c = !c_d[CHUNK_COUNT-1] ^ a_q[CHUNK_COUNT-1][WIDTH-1] ^ b_q[CHUNK_COUNT-1][WIDTH-1];
`endif

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (op_q[CHUNK_COUNT-1])
      OP_ADD: begin
        res_d   = r_d[CHUNK_COUNT-1][WIDTH-1:0];
        carry_d = c_d[CHUNK_COUNT-1];
      end
      OP_SUB: begin
        res_d   = r_d[CHUNK_COUNT-1][WIDTH-1:0];
        carry_d = !c_d[CHUNK_COUNT-1];
      end
      OP_EQ:  res_d[0] = e_d[CHUNK_COUNT-1];
      OP_NEQ: res_d[0] = !e_d[CHUNK_COUNT-1];
      OP_LTU: res_d[0] = !c_d[CHUNK_COUNT-1];
      OP_GTU: res_d[0] = c_d[CHUNK_COUNT-1] && !e_d[CHUNK_COUNT-1];
`ifdef MATH_PIPELINED_SIGNED_EN
      OP_LTS: res_d[0] = lts_c;
      OP_GTS: res_d[0] = !lts_c && !e_d[CHUNK_COUNT-1];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_op_q     <= 3'd0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= PW'(in_a);
      b_q[0]   <= PW'(in_b);
      op_q[0]  <= in_op;
      c_q[0]   <= (in_op != OP_ADD);
      e_q[0]   <= 1'b1;
      r_q[0]   <= '0;
      for (int k = 1; k < CHUNK_COUNT; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        op_q[k]  <= op_q[k-1];
        c_q[k]   <= c_d[k-1];
        e_q[k]   <= e_d[k-1];
        r_q[k]   <= r_d[k-1];
      end
      out_valid_q <= vld_q[CHUNK_COUNT-1];
      if (vld_q[CHUNK_COUNT-1]) begin
        out_result_q <= res_d;
        out_carry_q  <= carry_d;
        out_op_q     <= op_q[CHUNK_COUNT-1];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_op     = out_op_q;

endmodule
